// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: synchronised input, mid-bit 3-sample majority vote,
// configurable data width, parity and stop bits, with framing-error and break reporting.
module uart_rx_oversampled #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 Baud_Clk,
    input  logic                 Reset,
    input  logic                 Rx_In,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Valid,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Break_Det,
    output logic                 Busy
);

    localparam int unsigned M  = OVERSAMPLE / 2;
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned CW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TickS0   = TW'(M - 1);
    localparam logic [TW-1:0] TickS1   = TW'(M);
    localparam logic [TW-1:0] TickVote = TW'(M + 1);
    localparam logic [CW-1:0] DataLast = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] StopLast = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

    state_e               state_q;
    logic                 rx_meta_q, rx_s_q;
    logic [TW-1:0]        tick_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 stop_ok_q, stop_any_q;

    logic          vote, vote_edge, bit_end;
    logic [TW-1:0] tick_next;
    logic          parity_err_c, frame_err_c, break_c;

    always_comb begin
        vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        vote_edge = (tick_q == TickVote);
        bit_end   = (tick_q == TickLast);
        tick_next = bit_end ? '0 : tick_q + 1'b1;
        // Even mode expects XOR(data, parity) = 0, odd mode expects 1.
        parity_err_c = 1'b0;
        if (PARITY_MODE == 1) parity_err_c = ^{shift_q, parity_q};
        if (PARITY_MODE == 2) parity_err_c = ~(^{shift_q, parity_q});
        frame_err_c = ~(stop_ok_q & vote);
        break_c     = (shift_q == '0) && ((PARITY_MODE == 0) || !parity_q)
                      && !(stop_any_q | vote);
    end

    always_ff @(posedge Baud_Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            stop_ok_q  <= 1'b0;
            stop_any_q <= 1'b0;
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            Parity_Err <= 1'b0;
            Frame_Err  <= 1'b0;
            Break_Det  <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            rx_meta_q  <= Rx_In;
            rx_s_q     <= rx_meta_q;
            Data_Valid <= 1'b0;
            if (tick_q == TickS0) samp_q[0] <= rx_s_q;
            if (tick_q == TickS1) samp_q[1] <= rx_s_q;

            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q    <= StStart;
                        tick_q     <= TW'(1);
                        bit_cnt_q  <= '0;
                        stop_ok_q  <= 1'b1;
                        stop_any_q <= 1'b0;
                        Busy       <= 1'b1;
                    end
                end
                StStart: begin
                    tick_q <= tick_next;
                    if (vote_edge && vote) begin
                        state_q <= StIdle;
                        tick_q  <= '0;
                        Busy    <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    tick_q <= tick_next;
                    if (vote_edge) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == DataLast) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY_MODE != 0) ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    tick_q <= tick_next;
                    if (vote_edge) parity_q <= vote;
                    if (bit_end) state_q <= StStop;
                end
                StStop: begin
                    tick_q <= tick_next;
                    if (vote_edge) begin
                        stop_ok_q  <= stop_ok_q & vote;
                        stop_any_q <= stop_any_q | vote;
                        // Frame completes mid-stop-bit so an early next start is still caught.
                        if (bit_cnt_q == StopLast) begin
                            Data_Out   <= shift_q;
                            Parity_Err <= parity_err_c;
                            Frame_Err  <= frame_err_c;
                            Break_Det  <= break_c;
                            Data_Valid <= 1'b1;
                            tick_q     <= '0;
                            bit_cnt_q  <= '0;
                            if (frame_err_c) begin
                                state_q <= StWaitHigh;
                            end else begin
                                state_q <= StIdle;
                                Busy    <= 1'b0;
                            end
                        end
                    end else if (bit_end) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (rx_s_q) begin
                        state_q <= StIdle;
                        Busy    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: four instances cover 8N1, even parity,
// two stop bits and an 8x-oversampled 5-bit configuration.
module tb_uart_rx_oversampled;

    logic       Baud_Clk = 1'b0;
    logic       Reset;
    logic [3:0] rx;
    logic [7:0] d0, d1, d2;
    logic [4:0] d3;
    logic [3:0] dv, pe, fe, bd, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 Baud_Clk = ~Baud_Clk;
    always @(posedge Baud_Clk) cyc <= cyc + 1;

    uart_rx_oversampled u0 (
        .Baud_Clk(Baud_Clk), .Reset(Reset), .Rx_In(rx[0]), .Data_Out(d0), .Data_Valid(dv[0]),
        .Parity_Err(pe[0]), .Frame_Err(fe[0]), .Break_Det(bd[0]), .Busy(busy[0])
    );
    uart_rx_oversampled #(.PARITY_MODE(1)) u1 (
        .Baud_Clk(Baud_Clk), .Reset(Reset), .Rx_In(rx[1]), .Data_Out(d1), .Data_Valid(dv[1]),
        .Parity_Err(pe[1]), .Frame_Err(fe[1]), .Break_Det(bd[1]), .Busy(busy[1])
    );
    uart_rx_oversampled #(.STOP_BITS(2)) u2 (
        .Baud_Clk(Baud_Clk), .Reset(Reset), .Rx_In(rx[2]), .Data_Out(d2), .Data_Valid(dv[2]),
        .Parity_Err(pe[2]), .Frame_Err(fe[2]), .Break_Det(bd[2]), .Busy(busy[2])
    );
    uart_rx_oversampled #(.OVERSAMPLE(8), .DATA_BITS(5)) u3 (
        .Baud_Clk(Baud_Clk), .Reset(Reset), .Rx_In(rx[3]), .Data_Out(d3), .Data_Valid(dv[3]),
        .Parity_Err(pe[3]), .Frame_Err(fe[3]), .Break_Det(bd[3]), .Busy(busy[3])
    );

    // Per-instance record of completed frames and busy cycles.
    int         vcnt[4]  = '{default: 0};
    int         vcyc[4]  = '{default: 0};
    int         bcnt[4]  = '{default: 0};
    logic [7:0] vdata[4] = '{default: 8'h00};
    logic       vpe[4]   = '{default: 1'b0};
    logic       vfe[4]   = '{default: 1'b0};
    logic       vbd[4]   = '{default: 1'b0};
    logic [5:0] hist3[$];

    always @(negedge Baud_Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (busy[i] === 1'b1) bcnt[i] <= bcnt[i] + 1;
            if (dv[i] === 1'b1) begin
                vcnt[i]  <= vcnt[i] + 1;
                vcyc[i]  <= cyc;
                vpe[i]   <= pe[i];
                vfe[i]   <= fe[i];
                vbd[i]   <= bd[i];
                vdata[i] <= (i == 0) ? d0 : (i == 1) ? d1 : (i == 2) ? d2 : {3'b000, d3};
            end
        end
        if (dv[3] === 1'b1) hist3.push_back({fe[3], d3});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Baud_Clk);
            #1;
        end
    endtask

    task automatic drive_line(input int sel, input logic v, input int n);
        rx[sel] = v;
        tick(n);
    endtask

    task automatic send_frame(input int sel, input int os, input logic [15:0] bits,
                              input int nbits);
        for (int i = 0; i < nbits; i++) drive_line(sel, bits[i], os);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        rx    = 4'hF;
        tick(3);
        total++; if (dv !== 4'h0) begin bad++; $display("FAIL reset_valid got=%h exp=0", dv); end
        total++; if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
        total++; if ((pe | fe | bd) !== 4'h0) begin
            bad++; $display("FAIL reset_flags pe=%h fe=%h bd=%h exp=0", pe, fe, bd);
        end
        total++; if (d0 !== 8'h00 || d3 !== 5'h00) begin
            bad++; $display("FAIL reset_data got=%h/%h exp=0/0", d0, d3);
        end
        Reset = 1'b0;
        tick(5);
        total++; if (busy !== 4'h0) begin bad++; $display("FAIL idle_busy got=%h exp=0", busy); end
    endtask

    task automatic test_frame_8n1;
        int p, c, b;
        p = cyc; c = vcnt[0]; b = bcnt[0];
        send_frame(0, 16, {1'b1, 8'hA5, 1'b0}, 10);
        tick(20);
        total++; if (vcnt[0] - c !== 1) begin
            bad++; $display("FAIL a5_count got=%0d exp=1", vcnt[0] - c);
        end
        total++; if (vdata[0] !== 8'hA5) begin
            bad++; $display("FAIL a5_data got=%h exp=a5", vdata[0]);
        end
        total++; if ({vpe[0], vfe[0], vbd[0]} !== 3'b000) begin
            bad++; $display("FAIL a5_flags got=%b exp=000", {vpe[0], vfe[0], vbd[0]});
        end
        total++; if (vcyc[0] !== p + 156) begin
            bad++; $display("FAIL a5_latency got=%0d exp=%0d", vcyc[0], p + 156);
        end
        total++; if (bcnt[0] - b !== 153) begin
            bad++; $display("FAIL a5_busy_cycles got=%0d exp=153", bcnt[0] - b);
        end
    endtask

    task automatic test_glitch;
        int c, b;
        c = vcnt[0]; b = bcnt[0];
        drive_line(0, 1'b0, 3);
        drive_line(0, 1'b1, 40);
        total++; if (vcnt[0] !== c) begin
            bad++; $display("FAIL glitch_valid got=%0d exp=%0d", vcnt[0], c);
        end
        total++; if (bcnt[0] - b < 1 || bcnt[0] - b > 10) begin
            bad++; $display("FAIL glitch_busy got=%0d exp=1..10", bcnt[0] - b);
        end
    endtask

    task automatic test_parity;
        int c;
        c = vcnt[1];
        send_frame(1, 16, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
        tick(20);
        total++; if (vcnt[1] - c !== 1) begin
            bad++; $display("FAIL par0_count got=%0d exp=1", vcnt[1] - c);
        end
        total++; if (vdata[1] !== 8'h07) begin
            bad++; $display("FAIL par0_data got=%h exp=07", vdata[1]);
        end
        total++; if (vpe[1] !== 1'b1) begin
            bad++; $display("FAIL par0_err got=%b exp=1", vpe[1]);
        end
        send_frame(1, 16, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        tick(20);
        total++; if (vcnt[1] - c !== 2) begin
            bad++; $display("FAIL par1_count got=%0d exp=2", vcnt[1] - c);
        end
        total++; if (vpe[1] !== 1'b0 || vdata[1] !== 8'h07) begin
            bad++; $display("FAIL par1_err got=%b/%h exp=0/07", vpe[1], vdata[1]);
        end
    endtask

    task automatic test_two_stop;
        int c;
        c = vcnt[2];
        send_frame(2, 16, {1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        tick(200);
        total++; if (vcnt[2] - c !== 1) begin
            bad++; $display("FAIL stop2_count got=%0d exp=1", vcnt[2] - c);
        end
        total++; if (vdata[2] !== 8'h3C) begin
            bad++; $display("FAIL stop2_data got=%h exp=3c", vdata[2]);
        end
        total++; if ({vfe[2], vbd[2]} !== 2'b10) begin
            bad++; $display("FAIL stop2_flags fe_bd got=%b exp=10", {vfe[2], vbd[2]});
        end
        total++; if (busy[2] !== 1'b1) begin
            bad++; $display("FAIL stop2_wait_busy got=%b exp=1", busy[2]);
        end
        drive_line(2, 1'b1, 20);
        total++; if (busy[2] !== 1'b0) begin
            bad++; $display("FAIL stop2_release_busy got=%b exp=0", busy[2]);
        end
        send_frame(2, 16, {2'b11, 8'h81, 1'b0}, 11);
        tick(20);
        total++; if (vcnt[2] - c !== 2 || vdata[2] !== 8'h81 || vfe[2] !== 1'b0) begin
            bad++; $display("FAIL stop2_next got=%0d/%h/%b exp=2/81/0", vcnt[2] - c, vdata[2],
                            vfe[2]);
        end
    endtask

    task automatic test_break;
        int c;
        c = vcnt[0];
        drive_line(0, 1'b0, 480);
        total++; if (vcnt[0] - c !== 1) begin
            bad++; $display("FAIL break_count got=%0d exp=1", vcnt[0] - c);
        end
        total++; if (vdata[0] !== 8'h00) begin
            bad++; $display("FAIL break_data got=%h exp=00", vdata[0]);
        end
        total++; if ({vfe[0], vbd[0]} !== 2'b11) begin
            bad++; $display("FAIL break_flags fe_bd got=%b exp=11", {vfe[0], vbd[0]});
        end
        total++; if (busy[0] !== 1'b1) begin
            bad++; $display("FAIL break_wait_busy got=%b exp=1", busy[0]);
        end
        drive_line(0, 1'b1, 20);
        send_frame(0, 16, {1'b1, 8'h5A, 1'b0}, 10);
        tick(20);
        total++; if (vcnt[0] - c !== 2 || vdata[0] !== 8'h5A) begin
            bad++; $display("FAIL break_next got=%0d/%h exp=2/5a", vcnt[0] - c, vdata[0]);
        end
        total++; if ({vfe[0], vbd[0]} !== 2'b00) begin
            bad++; $display("FAIL break_next_flags got=%b exp=00", {vfe[0], vbd[0]});
        end
    endtask

    task automatic test_back_to_back;
        int c, n;
        c = vcnt[3];
        send_frame(3, 8, {5'h15, 1'b0}, 6);
        drive_line(3, 1'b1, 5);
        send_frame(3, 8, {1'b1, 5'h0A, 1'b0}, 7);
        tick(20);
        n = hist3.size();
        total++; if (vcnt[3] - c !== 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", vcnt[3] - c);
        end
        total++; if (n < 2) begin
            bad++; $display("FAIL b2b_first got=none exp=15");
        end else if (hist3[n-2] !== 6'h15) begin
            bad++; $display("FAIL b2b_first fe_data got=%h exp=15", hist3[n-2]);
        end
        total++; if (n < 1) begin
            bad++; $display("FAIL b2b_second got=none exp=0a");
        end else if (hist3[n-1] !== 6'h0A) begin
            bad++; $display("FAIL b2b_second fe_data got=%h exp=0a", hist3[n-1]);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        c = vcnt[0];
        drive_line(0, 1'b0, 16);
        drive_line(0, 1'b1, 16);
        drive_line(0, 1'b0, 11);
        total++; if (busy[0] !== 1'b1) begin
            bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy[0]);
        end
        Reset = 1'b1;
        #1;
        total++; if (d0 !== 8'h00 || busy[0] !== 1'b0 || dv[0] !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs data=%h busy=%b valid=%b exp=00/0/0", d0,
                            busy[0], dv[0]);
        end
        total++; if ({pe[0], fe[0], bd[0]} !== 3'b000) begin
            bad++; $display("FAIL midrst_flags got=%b exp=000", {pe[0], fe[0], bd[0]});
        end
        rx[0] = 1'b1;
        tick(200);
        Reset = 1'b0;
        tick(50);
        total++; if (vcnt[0] !== c) begin
            bad++; $display("FAIL midrst_valid got=%0d exp=%0d", vcnt[0], c);
        end
        total++; if (busy[0] !== 1'b0) begin
            bad++; $display("FAIL midrst_busy_after got=%b exp=0", busy[0]);
        end
    endtask

    initial begin
        Reset = 1'b1;
        rx    = 4'hF;
        test_reset;
        test_frame_8n1;
        test_glitch;
        test_parity;
        test_two_stop;
        test_break;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
